nv_nvdla_cdp_dp_nanproc: RTL

NV_NVDLA_CDP_DP_NANPROC -- requirements
Module: NV_NVDLA_CDP_DP_nanproc

---
 rtl/nv_nvdla_cdp_dp_nanproc.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/nv_nvdla_cdp_dp_nanproc.sv
// ============================================================================
// Module  : nv_nvdla_cdp_dp_nanproc
// Purpose : CDP fp16 NaN pre-processing with optional NaN/Inf layer counters
//           (counting built only when NVDLA_CDP_NAN_CNT_EN is defined).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nv_nvdla_cdp_dp_nanproc #(
  parameter int TP  = 8,
  parameter int BPE = 16,
  localparam int DW = TP*BPE,
  localparam int PW = DW+23
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          cdp_rdma2dp_valid,
  output logic          cdp_rdma2dp_ready,
  input  logic [PW-1:0] cdp_rdma2dp_pd,
  output logic          nan_preproc_pvld,
  input  logic          nan_preproc_prdy,
  output logic [PW-1:0] nan_preproc_pd,
  input  logic          reg2dp_op_en,
  input  logic [1:0]    reg2dp_input_data_type,
  input  logic          reg2dp_nan_to_zero,
  input  logic          dp2reg_done,
  output logic [31:0]   dp2reg_nan_input_num,
  output logic [31:0]   dp2reg_inf_input_num
);

  localparam int CW = $clog2(TP+1);

  logic          r_op_en_d1;
  logic          r_fp16_en;
  logic          r_tozero_en;
  logic          r_waiting;
  logic          r_pvld;
  logic [PW-1:0] r_pd;
  logic          w_op_en_load;
  logic          w_load;
  logic          w_layer_end;
  logic [DW-1:0] w_data_out;
  logic [TP-1:0] w_is_nan;

  assign w_op_en_load      = reg2dp_op_en & ~r_op_en_d1;
  assign cdp_rdma2dp_ready = (~r_pvld | nan_preproc_prdy) & ~r_waiting;
  assign w_load            = cdp_rdma2dp_valid & cdp_rdma2dp_ready;
  assign w_layer_end       = w_load & (&cdp_rdma2dp_pd[DW+14:DW+8]);
  assign nan_preproc_pvld  = r_pvld;
  assign nan_preproc_pd    = r_pd;

  // Modes are latched only while idle so an op_en re-pulse mid-layer is ignored.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_op_en_d1  <= 1'b0;
      r_fp16_en   <= 1'b0;
      r_tozero_en <= 1'b0;
      r_waiting   <= 1'b1;
    end else begin
      r_op_en_d1 <= reg2dp_op_en;
      if (w_op_en_load & r_waiting) begin
        r_fp16_en   <= (reg2dp_input_data_type == 2'd2) && (BPE == 16);
        r_tozero_en <= reg2dp_nan_to_zero;
      end
      if (w_layer_end)
        r_waiting <= 1'b1;
      else if (w_op_en_load)
        r_waiting <= 1'b0;
    end
  end

`ifdef NVDLA_CDP_NAN_CNT_EN
  logic [TP-1:0] w_is_inf;
`endif

  for (genvar e = 0; e < TP; e++) begin : g_elem
    if (BPE == 16) begin : g_fp16
      logic [15:0] w_elem;
      assign w_elem      = cdp_rdma2dp_pd[e*16 +: 16];
      assign w_is_nan[e] = r_fp16_en & (&w_elem[14:10]) & (|w_elem[9:0]);
`ifdef NVDLA_CDP_NAN_CNT_EN
      assign w_is_inf[e] = r_fp16_en & (&w_elem[14:10]) & ~(|w_elem[9:0]);
`endif
      assign w_data_out[e*16 +: 16] = (w_is_nan[e] & r_tozero_en) ? 16'h0000 : w_elem;
    end else begin : g_pass
      assign w_is_nan[e] = 1'b0;
`ifdef NVDLA_CDP_NAN_CNT_EN
      assign w_is_inf[e] = 1'b0;
`endif
      assign w_data_out[e*BPE +: BPE] = cdp_rdma2dp_pd[e*BPE +: BPE];
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_pvld <= 1'b0;
      r_pd   <= '0;
    end else if (w_load) begin
      r_pvld <= 1'b1;
      r_pd   <= {cdp_rdma2dp_pd[PW-1:DW], w_data_out};
    end else if (nan_preproc_prdy) begin
      r_pvld <= 1'b0;
    end
  end

`ifdef NVDLA_CDP_NAN_CNT_EN
  logic [CW-1:0] w_nan_beat;
  logic [CW-1:0] w_inf_beat;
  logic [31:0]   w_nan_next;
  logic [31:0]   w_inf_next;
  logic          w_cube_end;
  logic [31:0]   r_nan_cnt, r_inf_cnt;
  logic [31:0]   r_nan_slot0, r_nan_slot1, r_inf_slot0, r_inf_slot1;
  logic [31:0]   r_nan_pub, r_inf_pub;
  logic          r_layer_flag, r_wdma_flag;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [CW-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_comb begin
    w_nan_beat = '0;
    w_inf_beat = '0;
    for (int e = 0; e < TP; e++) begin
      w_nan_beat = w_nan_beat + CW'(w_is_nan[e]);
      w_inf_beat = w_inf_beat + CW'(w_is_inf[e]);
    end
  end

  assign w_nan_next = sat_add(r_nan_cnt, w_nan_beat);
  assign w_inf_next = sat_add(r_inf_cnt, w_inf_beat);
  assign w_cube_end = w_load & (&cdp_rdma2dp_pd[DW+14:DW+12]);

  // Ping-pong slots let a done pulse publish layer N while layer N+1 counts.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_nan_cnt    <= '0;
      r_inf_cnt    <= '0;
      r_nan_slot0  <= '0;
      r_nan_slot1  <= '0;
      r_inf_slot0  <= '0;
      r_inf_slot1  <= '0;
      r_nan_pub    <= '0;
      r_inf_pub    <= '0;
      r_layer_flag <= 1'b0;
      r_wdma_flag  <= 1'b0;
    end else begin
      if (w_cube_end) begin
        if (r_layer_flag) begin
          r_nan_slot1 <= w_nan_next;
          r_inf_slot1 <= w_inf_next;
        end else begin
          r_nan_slot0 <= w_nan_next;
          r_inf_slot0 <= w_inf_next;
        end
        r_layer_flag <= ~r_layer_flag;
        r_nan_cnt    <= '0;
        r_inf_cnt    <= '0;
      end else if (w_load) begin
        r_nan_cnt <= w_nan_next;
        r_inf_cnt <= w_inf_next;
      end
      if (dp2reg_done) begin
        r_nan_pub   <= r_wdma_flag ? r_nan_slot1 : r_nan_slot0;
        r_inf_pub   <= r_wdma_flag ? r_inf_slot1 : r_inf_slot0;
        r_wdma_flag <= ~r_wdma_flag;
      end
    end
  end

  assign dp2reg_nan_input_num = r_nan_pub;
  assign dp2reg_inf_input_num = r_inf_pub;
`else
  assign dp2reg_nan_input_num = 32'd0;
  assign dp2reg_inf_input_num = 32'd0;
`endif

endmodule

`default_nettype wire
